// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator machine: opcodes, ALU codes,
// sequencer state encoding and instruction field positions.
package cpu_pkg;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int ADDR_MSB = 11;
  localparam int ADDR_LSB = 0;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_SHR   = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_JN    = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;
  localparam logic [3:0] ALU_SHL = 4'b0100;
  localparam logic [3:0] ALU_SHR = 4'b0101;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_F_ADDR  = 4'd1;
  localparam logic [3:0] ST_F_WAIT  = 4'd2;
  localparam logic [3:0] ST_F_MBR   = 4'd3;
  localparam logic [3:0] ST_F_IR    = 4'd4;
  localparam logic [3:0] ST_DECODE  = 4'd5;
  localparam logic [3:0] ST_E_ADDR  = 4'd6;
  localparam logic [3:0] ST_E_WAIT  = 4'd7;
  localparam logic [3:0] ST_E_MBR   = 4'd8;
  localparam logic [3:0] ST_E_ACC   = 4'd9;
  localparam logic [3:0] ST_E_STORE = 4'd10;
  localparam logic [3:0] ST_E_WRITE = 4'd11;
  localparam logic [3:0] ST_E_JMP   = 4'd12;
  localparam logic [3:0] ST_RETIRE  = 4'd13;
  localparam logic [3:0] ST_HALTED  = 4'd14;
  localparam logic [3:0] ST_TRAP    = 4'd15;

  typedef enum logic [3:0] {
    S_IDLE    = ST_IDLE,
    S_F_ADDR  = ST_F_ADDR,
    S_F_WAIT  = ST_F_WAIT,
    S_F_MBR   = ST_F_MBR,
    S_F_IR    = ST_F_IR,
    S_DECODE  = ST_DECODE,
    S_E_ADDR  = ST_E_ADDR,
    S_E_WAIT  = ST_E_WAIT,
    S_E_MBR   = ST_E_MBR,
    S_E_ACC   = ST_E_ACC,
    S_E_STORE = ST_E_STORE,
    S_E_WRITE = ST_E_WRITE,
    S_E_JMP   = ST_E_JMP,
    S_RETIRE  = ST_RETIRE,
    S_HALTED  = ST_HALTED,
    S_TRAP    = ST_TRAP
  } seq_state_t;

  function automatic logic [3:0] alu_code(input logic [3:0] op);
    case (op)
      OP_SUB:  alu_code = ALU_SUB;
      OP_AND:  alu_code = ALU_AND;
      OP_OR:   alu_code = ALU_OR;
      OP_XOR:  alu_code = ALU_XOR;
      OP_SHL:  alu_code = ALU_SHL;
      OP_SHR:  alu_code = ALU_SHR;
      default: alu_code = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/status bundle between cpu_sequencer (master) and the accumulator
// datapath, memory and ALU (slave).
interface cpu_sequencer_if
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic                       start;
  logic [OPC_MSB-OPC_LSB:0]   ir_opcode;
  logic                       acc_zero;
  logic                       acc_neg;
  logic                       mar_write;
  logic                       mar_sel;
  logic                       mbr_write;
  logic                       mbr_sel;
  logic                       ir_write;
  logic                       pc_write;
  logic                       pc_sel;
  logic                       acc_write;
  logic                       acc_sel;
  logic                       mem_write;
  logic [3:0]                 alu_opcode;
  logic                       halted;
  logic                       illegal;
  logic [CNT_W-1:0]           retired;

  modport master (
    input  start, ir_opcode, acc_zero, acc_neg,
    output mar_write, mar_sel, mbr_write, mbr_sel, ir_write, pc_write, pc_sel,
           acc_write, acc_sel, mem_write, alu_opcode, halted, illegal, retired
  );

  modport slave (
    output start, ir_opcode, acc_zero, acc_neg,
    input  mar_write, mar_sel, mbr_write, mbr_sel, ir_write, pc_write, pc_sel,
           acc_write, acc_sel, mem_write, alu_opcode, halted, illegal, retired
  );
endinterface

// File: rtl/seq_wait_timer.sv
// Loadable down-counter that times memory wait states; done is high while the
// count sits at zero.
module seq_wait_timer #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)            cnt_q <= '0;
    else if (load)           cnt_q <= load_val;
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control FSM for the 16-bit accumulator machine.
// Define SEQ_ILLEGAL_TRAP_EN to trap opcodes C/D/E; otherwise they run as NOP.
//
// state    | meaning
// IDLE     | waiting for start after reset
// F_ADDR   | MAR <= PC
// F_WAIT   | memory read latency for the fetch
// F_MBR    | MBR <= memory
// F_IR     | IR <= MBR, PC <= PC+1
// DECODE   | latch opcode and ACC flags, choose execute path
// E_ADDR   | MAR <= IR address
// E_WAIT   | memory read latency for the operand
// E_MBR    | MBR <= memory
// E_ACC    | ACC <= MBR or ALU result
// E_STORE  | MBR <= ACC
// E_WRITE  | memory write
// E_JMP    | PC <= IR address
// RETIRE   | count instruction, back to fetch
// HALTED   | HALT executed, waiting for start
// TRAP     | illegal opcode, only reset leaves
module cpu_sequencer #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  cpu_sequencer_if.master bus
);
  import cpu_pkg::*;

  seq_state_t       state_q, state_d;
  logic [3:0]       opc_q;
  logic             zero_q, neg_q;
  logic [CNT_W-1:0] retired_q;
  logic             tmr_load, tmr_done;
  logic             retire_inc;
  logic             jmp_taken;

  seq_wait_timer #(.W(3)) u_wait_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (3'(MEM_LATENCY - 1)),
    .done     (tmr_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_F_ADDR;
      S_F_ADDR:  begin
        tmr_load = 1'b1;
        state_d  = S_F_WAIT;
      end
      S_F_WAIT:  if (tmr_done) state_d = S_F_MBR;
      S_F_MBR:   state_d = S_F_IR;
      S_F_IR:    state_d = S_DECODE;
      S_DECODE: begin
        case (bus.ir_opcode)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB,
          OP_AND, OP_OR, OP_XOR:  state_d = S_E_ADDR;
          OP_SHL, OP_SHR:         state_d = S_E_ACC;
          OP_JUMP:                state_d = S_E_JMP;
          OP_JZ:                  state_d = bus.acc_zero ? S_E_JMP : S_RETIRE;
          OP_JN:                  state_d = bus.acc_neg  ? S_E_JMP : S_RETIRE;
          OP_HALT:                state_d = S_HALTED;
`ifdef SEQ_ILLEGAL_TRAP_EN
          default:                state_d = S_TRAP;
`else
          default:                state_d = S_RETIRE;
`endif
        endcase
      end
      S_E_ADDR: begin
        tmr_load = 1'b1;
        state_d  = (opc_q == OP_STORE) ? S_E_STORE : S_E_WAIT;
      end
      S_E_WAIT:  if (tmr_done) state_d = S_E_MBR;
      S_E_MBR:   state_d = S_E_ACC;
      S_E_ACC:   state_d = S_RETIRE;
      S_E_STORE: state_d = S_E_WRITE;
      S_E_WRITE: state_d = S_RETIRE;
      S_E_JMP:   state_d = S_RETIRE;
      S_RETIRE:  state_d = S_F_ADDR;
      S_HALTED:  if (bus.start) state_d = S_F_ADDR;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_IDLE;
    endcase
  end

  // Flags are captured with the opcode so the jump strobe reflects DECODE-time ACC.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      opc_q  <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (state_q == S_DECODE) begin
      opc_q  <= bus.ir_opcode;
      zero_q <= bus.acc_zero;
      neg_q  <= bus.acc_neg;
    end
  end

  assign retire_inc = (state_q == S_RETIRE) ||
                      (state_q == S_DECODE && state_d == S_HALTED);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        retired_q <= '0;
    else if (retire_inc) retired_q <= retired_q + 1'b1;
  end

  assign jmp_taken = (opc_q == OP_JUMP) || (opc_q == OP_JZ && zero_q) ||
                     (opc_q == OP_JN && neg_q);

  always_comb begin
    bus.mar_write  = 1'b0;
    bus.mar_sel    = 1'b0;
    bus.mbr_write  = 1'b0;
    bus.mbr_sel    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_sel     = 1'b0;
    bus.acc_write  = 1'b0;
    bus.acc_sel    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.alu_opcode = 4'b0000;
    bus.halted     = 1'b0;
    case (state_q)
      S_F_ADDR:  bus.mar_write = 1'b1;
      S_F_MBR:   bus.mbr_write = 1'b1;
      S_F_IR: begin
        bus.ir_write = 1'b1;
        bus.pc_write = 1'b1;
      end
      S_E_ADDR: begin
        bus.mar_write = 1'b1;
        bus.mar_sel   = 1'b1;
      end
      S_E_MBR:   bus.mbr_write = 1'b1;
      S_E_ACC: begin
        bus.acc_write = 1'b1;
        if (opc_q != OP_LOAD) begin
          bus.acc_sel    = 1'b1;
          bus.alu_opcode = alu_code(opc_q);
        end
      end
      S_E_STORE: begin
        bus.mbr_write = 1'b1;
        bus.mbr_sel   = 1'b1;
      end
      S_E_WRITE: bus.mem_write = 1'b1;
      S_E_JMP: begin
        bus.pc_write = jmp_taken;
        bus.pc_sel   = jmp_taken;
      end
      S_HALTED, S_TRAP: bus.halted = 1'b1;
      default: ;
    endcase
  end

`ifdef SEQ_ILLEGAL_TRAP_EN
  assign bus.illegal = (state_q == S_TRAP);
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer; a second 4-bit-counter instance runs in
// lockstep to show the retired counter wrapping from all-ones to zero.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int ML = 1;

  localparam logic [9:0] C_MARW = 10'b10_0000_0000;
  localparam logic [9:0] C_MARS = 10'b01_0000_0000;
  localparam logic [9:0] C_MBRW = 10'b00_1000_0000;
  localparam logic [9:0] C_IRW  = 10'b00_0010_0000;
  localparam logic [9:0] C_PCW  = 10'b00_0001_0000;
  localparam logic [9:0] C_ACCW = 10'b00_0000_0100;

  logic clock;
  logic reset_n;

  cpu_sequencer_if #(.CNT_W(16)) sif ();
  cpu_sequencer_if #(.CNT_W(4))  sif4 ();

  assign sif4.start     = sif.start;
  assign sif4.ir_opcode = sif.ir_opcode;
  assign sif4.acc_zero  = sif.acc_zero;
  assign sif4.acc_neg   = sif.acc_neg;

  cpu_sequencer #(.MEM_LATENCY(ML), .CNT_W(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (sif)
  );

  cpu_sequencer #(.MEM_LATENCY(ML), .CNT_W(4)) dut4 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (sif4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int exp_retired = 0;

  typedef struct {
    logic [3:0] op;
    logic       z;
    logic       n;
    logic       hold_start;
    int         cyc;
    int         pcw;
    int         accw;
    logic [3:0] alu;
    logic       accs;
    int         memw;
    int         mbrw;
  } vec_t;

  vec_t vecs[$];
  logic [9:0] load_exp [10];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ctl_now();
    return {sif.mar_write, sif.mar_sel, sif.mbr_write, sif.mbr_sel, sif.ir_write,
            sif.pc_write, sif.pc_sel, sif.acc_write, sif.acc_sel, sif.mem_write};
  endfunction

  function automatic logic [31:0] all_out();
    return {ctl_now(), sif.alu_opcode, sif.halted, sif.illegal, sif.retired};
  endfunction

  function automatic vec_t mk(logic [3:0] op, logic z, logic n, logic hs, int cyc, int pcw,
                              int accw, logic [3:0] alu, logic accs, int memw, int mbrw);
    vec_t v;
    v.op = op; v.z = z; v.n = n; v.hold_start = hs; v.cyc = cyc; v.pcw = pcw;
    v.accw = accw; v.alu = alu; v.accs = accs; v.memw = memw; v.mbrw = mbrw;
    return v;
  endfunction

  // Returns at the negedge inside F_IR, where the bench plays the role of the IR.
  task automatic wait_ir();
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (sif.ir_write) found = 1'b1;
    end
    if (!found) check("ir_write_timeout", 32'd0, 32'd1);
  endtask

  // Window runs from DECODE up to and including the next fetch F_ADDR.
  task automatic run_op(input vec_t v);
    int n_pcw = 0, n_accw = 0, n_memw = 0, n_mbrw = 0, cyc = 0, mbr_at = 0, mem_at = 0;
    logic [3:0] alu_seen = 4'h0;
    logic accs_seen = 1'b0, mbrs_seen = 1'b0, pcs_seen = 1'b0;
    bit done = 1'b0;
    string t;
    wait_ir();
    sif.ir_opcode = v.op;
    sif.acc_zero  = v.z;
    sif.acc_neg   = v.n;
    sif.start     = v.hold_start;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clock);
      if (c == 2) begin
        sif.acc_zero = ~v.z;
        sif.acc_neg  = ~v.n;
      end
      if (sif.pc_write) begin n_pcw++; pcs_seen = sif.pc_sel; end
      if (sif.acc_write) begin n_accw++; alu_seen = sif.alu_opcode; accs_seen = sif.acc_sel; end
      if (sif.mbr_write) begin n_mbrw++; mbrs_seen = sif.mbr_sel; mbr_at = c; end
      if (sif.mem_write) begin n_memw++; mem_at = c; end
      if (sif.mar_write && !sif.mar_sel) begin done = 1'b1; cyc = c; end
    end
    sif.start = 1'b0;
    exp_retired++;
    t = $sformatf("op%0h_z%0d_n%0d", v.op, v.z, v.n);
    check({t, "_cycles"},  cyc, v.cyc);
    check({t, "_pcw"},     n_pcw, v.pcw);
    if (n_pcw > 0) check({t, "_pc_sel"}, pcs_seen, 1);
    check({t, "_accw"},    n_accw, v.accw);
    check({t, "_alu"},     alu_seen, v.alu);
    check({t, "_acc_sel"}, accs_seen, v.accs);
    check({t, "_memw"},    n_memw, v.memw);
    check({t, "_mbrw"},    n_mbrw, v.mbrw);
    if (n_mbrw > 0) check({t, "_mbr_sel"}, mbrs_seen, (v.op == OP_STORE));
    if (n_memw > 0) check({t, "_store_order"}, mem_at, mbr_at + 1);
    check({t, "_retired"}, sif.retired, exp_retired);
    check({t, "_retired4"}, sif4.retired, exp_retired % 16);
    if (exp_retired == 16) check("wrap4_to_zero", sif4.retired, 0);
    check({t, "_illegal"}, sif.illegal, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int halted_cnt, strobe_cnt;
    bit found;

    reset_n       = 1'b0;
    sif.start     = 1'b0;
    sif.ir_opcode = 4'h0;
    sif.acc_zero  = 1'b0;
    sif.acc_neg   = 1'b0;

    load_exp[0] = C_MARW;          load_exp[1] = '0;
    load_exp[2] = C_MBRW;          load_exp[3] = C_IRW | C_PCW;
    load_exp[4] = '0;              load_exp[5] = C_MARW | C_MARS;
    load_exp[6] = '0;              load_exp[7] = C_MBRW;
    load_exp[8] = C_ACCW;          load_exp[9] = '0;

    //                op        z     n     hs    cyc pcw accw alu      accs memw mbrw
    vecs.push_back(mk(OP_STORE, 1'b0, 1'b0, 1'b0, 6, 0, 0, 4'b0000, 1'b0, 1, 1));
    vecs.push_back(mk(OP_ADD,   1'b0, 1'b0, 1'b1, 7, 0, 1, 4'b0000, 1'b1, 0, 1));
    vecs.push_back(mk(OP_SUB,   1'b0, 1'b0, 1'b0, 7, 0, 1, 4'b0001, 1'b1, 0, 1));
    vecs.push_back(mk(OP_AND,   1'b0, 1'b0, 1'b0, 7, 0, 1, 4'b1000, 1'b1, 0, 1));
    vecs.push_back(mk(OP_OR,    1'b0, 1'b0, 1'b0, 7, 0, 1, 4'b1001, 1'b1, 0, 1));
    vecs.push_back(mk(OP_XOR,   1'b0, 1'b0, 1'b0, 7, 0, 1, 4'b1010, 1'b1, 0, 1));
    vecs.push_back(mk(OP_LOAD,  1'b0, 1'b0, 1'b0, 7, 0, 1, 4'b0000, 1'b0, 0, 1));
    vecs.push_back(mk(OP_SHL,   1'b0, 1'b0, 1'b0, 4, 0, 1, 4'b0100, 1'b1, 0, 0));
    vecs.push_back(mk(OP_SHR,   1'b0, 1'b0, 1'b0, 4, 0, 1, 4'b0101, 1'b1, 0, 0));
    vecs.push_back(mk(OP_JUMP,  1'b0, 1'b0, 1'b0, 4, 1, 0, 4'b0000, 1'b0, 0, 0));
    vecs.push_back(mk(OP_JZ,    1'b1, 1'b0, 1'b0, 4, 1, 0, 4'b0000, 1'b0, 0, 0));
    vecs.push_back(mk(OP_JZ,    1'b0, 1'b0, 1'b0, 3, 0, 0, 4'b0000, 1'b0, 0, 0));
    vecs.push_back(mk(OP_JZ,    1'b0, 1'b1, 1'b0, 3, 0, 0, 4'b0000, 1'b0, 0, 0));
    vecs.push_back(mk(OP_JN,    1'b0, 1'b1, 1'b0, 4, 1, 0, 4'b0000, 1'b0, 0, 0));
    vecs.push_back(mk(OP_JN,    1'b1, 1'b0, 1'b0, 3, 0, 0, 4'b0000, 1'b0, 0, 0));
`ifndef SEQ_ILLEGAL_TRAP_EN
    vecs.push_back(mk(4'hD,     1'b0, 1'b0, 1'b0, 3, 0, 0, 4'b0000, 1'b0, 0, 0));
`endif

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      sif.start     = 1'($urandom);
      sif.ir_opcode = 4'($urandom);
      sif.acc_zero  = 1'($urandom);
      sif.acc_neg   = 1'($urandom);
      #1;
      check($sformatf("reset_outputs_%0d", i), all_out(), 32'h0);
    end
    @(negedge clock);
    sif.start = 1'b0; sif.ir_opcode = OP_LOAD; sif.acc_zero = 1'b0; sif.acc_neg = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check($sformatf("idle_no_strobe_%0d", i), all_out(), 32'h0);
    end

    // LOAD strobe timeline, cycle 1 is the first cycle after start
    sif.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      sif.start = 1'b0;
      check($sformatf("load_seq_c%0d", c), ctl_now(), load_exp[c-1]);
    end
    check("load_retired_before", sif.retired, 0);
    @(negedge clock);
    exp_retired = 1;
    check("load_retired_after", sif.retired, 1);
    check("load_refetch", ctl_now(), C_MARW);

    foreach (vecs[i]) run_op(vecs[i]);

    // HALT holds until start, and counts as retired
    wait_ir();
    sif.ir_opcode = OP_HALT;
    @(negedge clock);
    halted_cnt = 0; strobe_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (sif.halted) halted_cnt++;
      if (ctl_now() != '0) strobe_cnt++;
    end
    exp_retired++;
    check("halt_held", halted_cnt, 20);
    check("halt_no_strobe", strobe_cnt, 0);
    check("halt_retired", sif.retired, exp_retired);
    sif.start = 1'b1;
    @(negedge clock);
    sif.start = 1'b0;
    check("halt_resume_fetch", ctl_now(), C_MARW);
    check("halt_resume_halted", sif.halted, 0);

    // Reset asserted during E_WRITE drops mem_write without waiting for a clock
    wait_ir();
    sif.ir_opcode = OP_STORE;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (sif.mem_write) found = 1'b1;
    end
    check("ewrite_reached", found, 1);
    reset_n = 1'b0;
    #1;
    check("reset_mem_write", sif.mem_write, 0);
    check("reset_mid_outputs", all_out(), 32'h0);
    check("reset_mid_retired4", sif4.retired, 0);
    @(negedge clock);
    reset_n = 1'b1;
    exp_retired = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("post_reset_idle_%0d", i), all_out(), 32'h0);
    end

`ifdef SEQ_ILLEGAL_TRAP_EN
    sif.start = 1'b1;
    @(negedge clock);
    sif.start = 1'b0;
    wait_ir();
    sif.ir_opcode = 4'hD;
    @(negedge clock);
    @(negedge clock);
    check("trap_illegal", sif.illegal, 1);
    check("trap_halted", sif.halted, 1);
    check("trap_not_retired", sif.retired, 0);
    strobe_cnt = 0;
    sif.start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 3) sif.start = 1'b0;
      if (ctl_now() != '0) strobe_cnt++;
    end
    check("trap_start_ignored", strobe_cnt, 0);
    check("trap_sticky", sif.illegal, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
